lsu_pipe: RTL and testbench
===========================

Name: lsu_pipe

Overview:
- Parametrised handshake load/store unit for the next-generation RV core.
- Replaces the single-cycle combinational sign-extension and store-strobe path and the fixed one-cycle load stall.
- Sits between the execute stage (ALU address, rs2 data, funct3 size, rd) and a data memory with request/grant and read-valid signalling, so memory latency can vary.
- Supports XLEN 32 or 64 and produces a busy/stall signal for the PC and instruction path.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- SB_W, XLEN/8, byte-strobe width; derived, not overridable.
- RESET_PC_SAFE, 1, when 1 resp_data is forced to 0 whenever resp_valid=0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a load/store
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- req_addr  in  XLEN  byte address (ALU output)
- req_wdata  in  XLEN  store data (rs2)
- req_rd  in  5  load destination register
- resp_valid  out  1  one-cycle pulse: load data ready
- resp_data  out  XLEN  sign/zero-extended load result
- resp_rd  out  5  destination of resp_data
- busy  out  1  stall request to core (PC hold, NOP injection)
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request this cycle
- mem_addr  out  XLEN  address aligned to XLEN/8 bytes
- mem_we  out  SB_W  byte write strobes (all 0 for loads)
- mem_wdata  out  XLEN  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data
- err  out  1  misalignment/illegal-size pulse (optional feature only; else tied 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_rd=0; busy=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; err=0. Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&req_ready: latch we, size, addr, wdata, rd. Next state REQ.
  - busy=req_valid combinationally, so the core stalls in the accept cycle.
- REQ:
  - mem_req=1 with stable mem_addr, mem_we, mem_wdata until mem_gnt.
  - On mem_gnt: a store returns to IDLE with no resp_valid; a load goes to WAIT.
- WAIT:
  - mem_req=0. Capture on mem_rvalid; registered resp_valid=1 next cycle with resp_rd. Next state IDLE.
  - mem_rvalid outside WAIT is ignored. Memory guarantees rvalid at least one cycle after gnt.
- busy=1 in REQ and WAIT, and in the cycle resp_valid is high.
- Minimum latency: load accept to resp_valid = 3 cycles with gnt immediate and rvalid 1 cycle later. Store accept to req_ready = 2 cycles.
- Lane select: off = addr mod SB_W.
  - B: mem_we = 1<<off; data byte replicated across all lanes.
  - H: mem_we = 2'b11<<{off[..1],0}; halfword replicated.
  - W: mem_we = 4'hF<<{off[..2],00}.
  - D: all ones.
- Loads: extract the lane at off, then sign-extend (B, H, W) or zero-extend (BU, HU, WU) to XLEN. W at XLEN=32 passes through unchanged.
- Sizes D and WU with XLEN=32, and encoding 111, are illegal.
- Without the optional feature:
  - Illegal sizes are treated as a full-XLEN access.
  - Low address bits below the access size are ignored (forced aligned).
- Loads to rd=0 complete normally; the register bank discards the write.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned address (H not 2-aligned, W not 4-aligned, D not 8-aligned) or an illegal size is still accepted, but err pulses 1 cycle after accept. No memory request is made, resp_valid stays 0, and the FSM returns to IDLE.
- Undefined: err is tied 0 and the forced-alignment behaviour above applies.

Test Plan:
- Reset mid-WAIT: assert rst_n=0 during a pending load -> all outputs return to reset values immediately. A later mem_rvalid produces no resp_valid.
- XLEN=32, LB at addr 0x103, mem_rdata 0x80FF_1234 -> mem_addr 0x100; resp_data 0xFFFF_FF80; resp_rd echoes req_rd.
- XLEN=32, SH at addr 0x202 with wdata 0x0000_ABCD -> mem_we 4'b1100; mem_wdata 0xABCD_ABCD; no resp_valid.
- XLEN=64, LWU at addr 0x4, mem_rdata 0x8000_0001_0000_0000 -> resp_data 0x0000_0000_8000_0001.
- mem_gnt held 0 for 5 cycles -> mem_req and outputs stable; busy=1 throughout; req_ready=0 throughout.
- LSU_MISALIGN_TRAP_EN defined, LW at addr 0x6 -> err pulses once; mem_req never asserts; req_ready=1 two cycles after accept.

Source files
------------

// File: rtl/lsu_pipe.sv
// lsu_pipe: request/grant load/store unit that sits between execute and data memory, with lane steering and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned or illegal-size accesses raise err and skip memory.
module lsu_pipe #(
   parameter int XLEN          = 32,
   parameter int RESET_PC_SAFE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_data,
   output logic [4:0]        resp_rd,
   output logic              busy,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_we,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              err
);

   localparam int SB_W = XLEN / 8;
   localparam int LG   = (XLEN == 64) ? 3 : 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10
   } state_t;

   // Illegal encodings fall back to a full-XLEN access.
   function automatic logic [1:0] f_size_lg(input logic [2:0] sz);
      logic [1:0] lg;
      case (sz)
         3'b000, 3'b100: lg = 2'd0;
         3'b001, 3'b101: lg = 2'd1;
         3'b010, 3'b110: lg = 2'd2;
         default:        lg = (XLEN == 64) ? 2'd3 : 2'd2;
      endcase
      return lg;
   endfunction

   function automatic logic [2:0] f_align(input logic [2:0] off, input logic [1:0] lg);
      logic [2:0] a;
      case (lg)
         2'd0:    a = off;
         2'd1:    a = {off[2:1], 1'b0};
         2'd2:    a = {off[2], 2'b00};
         default: a = 3'b000;
      endcase
      return a;
   endfunction

   function automatic logic [SB_W-1:0] f_strobe(input logic [2:0] off, input logic [1:0] lg);
      logic [SB_W-1:0] b;
      case (lg)
         2'd0:    b = SB_W'(8'h01);
         2'd1:    b = SB_W'(8'h03);
         2'd2:    b = SB_W'(8'h0F);
         default: b = SB_W'(8'hFF);
      endcase
      return b << off;
   endfunction

   function automatic logic [XLEN-1:0] f_repl(input logic [XLEN-1:0] d, input logic [1:0] lg);
      logic [XLEN-1:0] r;
      case (lg)
         2'd0:    r = {SB_W{d[7:0]}};
         2'd1:    r = {(SB_W/2){d[15:0]}};
         2'd2:    r = {(SB_W/4){d[31:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] d, input logic [2:0] off,
                                                 input logic [1:0] lg, input logic uns);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] r;
      sh = d >> {off, 3'b000};
      case (lg)
         2'd0: begin
            if (uns) r = XLEN'(sh[7:0]);
            else     r = XLEN'($signed(sh[7:0]));
         end
         2'd1: begin
            if (uns) r = XLEN'(sh[15:0]);
            else     r = XLEN'($signed(sh[15:0]));
         end
         2'd2: begin
            if (uns) r = XLEN'(sh[31:0]);
            else     r = XLEN'($signed(sh[31:0]));
         end
         default: r = sh;
      endcase
      return r;
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic f_size_illegal(input logic [2:0] sz);
      logic ill;
      case (sz)
         3'b111:         ill = 1'b1;
         3'b011, 3'b110: ill = (XLEN == 32);
         default:        ill = 1'b0;
      endcase
      return ill;
   endfunction

   function automatic logic f_misaligned(input logic [2:0] off, input logic [1:0] lg);
      logic m;
      case (lg)
         2'd0:    m = 1'b0;
         2'd1:    m = off[0];
         2'd2:    m = |off[1:0];
         default: m = |off;
      endcase
      return m;
   endfunction
`endif

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic [1:0]        r_lg;
   logic              r_uns;
   logic [2:0]        r_off;
   logic [4:0]        r_rd;
   logic              r_trap;
   logic              r_mem_req;
   logic [XLEN-1:0]   r_mem_addr;
   logic [SB_W-1:0]   r_mem_we;
   logic [XLEN-1:0]   r_mem_wdata;
   logic              r_resp_valid;
   logic [XLEN-1:0]   r_resp_data;
   logic [4:0]        r_resp_rd;

   logic              w_accept;
   logic              w_trap;
   logic [1:0]        w_lg;
   logic [2:0]        w_off_raw;
   logic [2:0]        w_off;

   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_lg      = f_size_lg(req_size);
   assign w_off_raw = 3'(req_addr[LG-1:0]);
   assign w_off     = f_align(w_off_raw, w_lg);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_trap = f_size_illegal(req_size) | f_misaligned(w_off_raw, w_lg);
   assign err    = r_trap;
`else
   assign w_trap = 1'b0;
   assign err    = 1'b0;
`endif

   assign req_ready  = (r_state == S_IDLE);
   assign busy       = ((r_state == S_IDLE) ? req_valid : 1'b1) | r_resp_valid;
   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = r_mem_wdata;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_rd    = r_resp_rd;

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) w_next = S_REQ;
            else           w_next = S_IDLE;
         end
         S_REQ: begin
            if (r_trap)       w_next = S_IDLE;
            else if (mem_gnt) w_next = r_we ? S_IDLE : S_WAIT;
            else              w_next = S_REQ;
         end
         S_WAIT: begin
            if (mem_rvalid) w_next = S_IDLE;
            else            w_next = S_WAIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Request capture and memory-side outputs, held stable until grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we        <= 1'b0;
         r_lg        <= 2'd0;
         r_uns       <= 1'b0;
         r_off       <= 3'd0;
         r_rd        <= 5'd0;
         r_trap      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= '0;
         r_mem_wdata <= '0;
      end else if (w_accept) begin
         r_we        <= req_we;
         r_lg        <= w_lg;
         r_uns       <= req_size[2];
         r_off       <= w_off;
         r_rd        <= req_rd;
         r_trap      <= w_trap;
         r_mem_req   <= ~w_trap;
         r_mem_addr  <= {req_addr[XLEN-1:LG], {LG{1'b0}}};
         r_mem_we    <= (req_we && !w_trap) ? f_strobe(w_off, w_lg) : '0;
         r_mem_wdata <= f_repl(req_wdata, w_lg);
      end else if (r_state == S_REQ) begin
         r_trap <= 1'b0;
         if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= '0;
         end
      end
   end

   // Load response: one-cycle pulse, data cleared afterwards when RESET_PC_SAFE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_rd    <= 5'd0;
      end else if ((r_state == S_WAIT) && mem_rvalid) begin
         r_resp_valid <= 1'b1;
         r_resp_data  <= f_extract(mem_rdata, r_off, r_lg, r_uns);
         r_resp_rd    <= r_rd;
      end else begin
         r_resp_valid <= 1'b0;
         if (RESET_PC_SAFE != 0) r_resp_data <= '0;
      end
   end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed self-checking bench for lsu_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_lsu_pipe;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_busy, a_mem_req;
   logic        a_mem_gnt, a_mem_rvalid, a_err;
   logic [2:0]  a_req_size;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_data, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [4:0]  a_req_rd, a_resp_rd;
   logic [3:0]  a_mem_we;

   logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_busy, b_mem_req;
   logic        b_mem_gnt, b_mem_rvalid, b_err;
   logic [2:0]  b_req_size;
   logic [63:0] b_req_addr, b_req_wdata, b_resp_data, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [4:0]  b_req_rd, b_resp_rd;
   logic [7:0]  b_mem_we;

   lsu_pipe #(.XLEN(32)) u32 (
      .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_we(a_req_we), .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .req_rd(a_req_rd), .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_rd(a_resp_rd),
      .busy(a_busy), .mem_req(a_mem_req), .mem_gnt(a_mem_gnt), .mem_addr(a_mem_addr),
      .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rvalid(a_mem_rvalid),
      .mem_rdata(a_mem_rdata), .err(a_err)
   );

   lsu_pipe #(.XLEN(64)) u64 (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_we(b_req_we), .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .req_rd(b_req_rd), .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_rd(b_resp_rd),
      .busy(b_busy), .mem_req(b_mem_req), .mem_gnt(b_mem_gnt), .mem_addr(b_mem_addr),
      .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid),
      .mem_rdata(b_mem_rdata), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full load on the XLEN=32 instance: grant immediately, rvalid one cycle later.
   task automatic load32(input string tag, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = sz; a_req_addr = addr; a_req_rd = rd;
      #1 chk({tag, ".busy_accept"}, {63'd0, a_busy}, 64'd1);
      @(negedge clk);
      a_req_valid = 1'b0;
      chk({tag, ".mem_req"}, {63'd0, a_mem_req}, 64'd1);
      chk({tag, ".mem_addr"}, {32'd0, a_mem_addr}, {32'd0, exp_addr});
      chk({tag, ".mem_we"}, {60'd0, a_mem_we}, 64'd0);
      chk({tag, ".err"}, {63'd0, a_err}, 64'd0);
      a_mem_gnt = 1'b1;
      @(negedge clk);
      a_mem_gnt = 1'b0;
      chk({tag, ".wait_req"}, {63'd0, a_mem_req}, 64'd0);
      a_mem_rvalid = 1'b1; a_mem_rdata = rdata;
      @(negedge clk);
      a_mem_rvalid = 1'b0; a_mem_rdata = 32'h0;
      chk({tag, ".resp_valid"}, {63'd0, a_resp_valid}, 64'd1);
      chk({tag, ".resp_data"}, {32'd0, a_resp_data}, {32'd0, exp_data});
      chk({tag, ".resp_rd"}, {59'd0, a_resp_rd}, {59'd0, rd});
      chk({tag, ".busy_resp"}, {63'd0, a_busy}, 64'd1);
      @(negedge clk);
      chk({tag, ".resp_drop"}, {63'd0, a_resp_valid}, 64'd0);
      chk({tag, ".data_zero"}, {32'd0, a_resp_data}, 64'd0);
      chk({tag, ".busy_idle"}, {63'd0, a_busy}, 64'd0);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 3'd0; a_req_addr = 32'h0;
      a_req_wdata = 32'h0; a_req_rd = 5'd0; a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = 32'h0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 3'd0; b_req_addr = 64'h0;
      b_req_wdata = 64'h0; b_req_rd = 5'd0; b_mem_gnt = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = 64'h0;

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst.req_ready", {63'd0, a_req_ready}, 64'd1);
      chk("rst.resp_valid", {63'd0, a_resp_valid}, 64'd0);
      chk("rst.resp_data", {32'd0, a_resp_data}, 64'd0);
      chk("rst.busy", {63'd0, a_busy}, 64'd0);
      chk("rst.mem_req", {63'd0, a_mem_req}, 64'd0);
      chk("rst.mem_we", {60'd0, a_mem_we}, 64'd0);
      chk("rst.err", {63'd0, a_err}, 64'd0);
      chk("rst64.req_ready", {63'd0, b_req_ready}, 64'd1);
      rst_n = 1'b1;

      // LB sign-extension from lane 3
      load32("lb", 3'b000, 32'h0000_0103, 5'd5, 32'h80FF_1234, 32'h0000_0100, 32'hFFFF_FF80);
      // LBU from lane 1, LH from upper half
      load32("lbu", 3'b100, 32'h0000_0101, 5'd6, 32'h0000_F000, 32'h0000_0100, 32'h0000_00F0);
      load32("lh", 3'b001, 32'h0000_0102, 5'd0, 32'h8001_1234, 32'h0000_0100, 32'hFFFF_8001);

      // SH: strobe upper half, replicated data, no response
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 3'b001; a_req_addr = 32'h0000_0202;
      a_req_wdata = 32'h0000_ABCD; a_req_rd = 5'd7;
      @(negedge clk);
      a_req_valid = 1'b0; a_req_we = 1'b0;
      chk("sh.mem_we", {60'd0, a_mem_we}, 64'hC);
      chk("sh.mem_wdata", {32'd0, a_mem_wdata}, 64'hABCD_ABCD);
      chk("sh.mem_addr", {32'd0, a_mem_addr}, 64'h200);
      chk("sh.mem_req", {63'd0, a_mem_req}, 64'd1);
      a_mem_gnt = 1'b1;
      @(negedge clk);
      a_mem_gnt = 1'b0;
      chk("sh.req_ready", {63'd0, a_req_ready}, 64'd1);
      chk("sh.mem_req_drop", {63'd0, a_mem_req}, 64'd0);
      chk("sh.no_resp", {63'd0, a_resp_valid}, 64'd0);
      @(negedge clk);
      chk("sh.no_resp2", {63'd0, a_resp_valid}, 64'd0);

      // Grant stall for 5 cycles; stray rvalid during REQ is ignored
      @(negedge clk);
      a_req_valid = 1'b1; a_req_size = 3'b010; a_req_addr = 32'h0000_0010; a_req_rd = 5'd3;
      @(negedge clk);
      a_req_valid = 1'b0;
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'h5555_5555;
      for (int i = 0; i < 5; i++) begin
         chk("stall.mem_req", {63'd0, a_mem_req}, 64'd1);
         chk("stall.mem_addr", {32'd0, a_mem_addr}, 64'h10);
         chk("stall.busy", {63'd0, a_busy}, 64'd1);
         chk("stall.req_ready", {63'd0, a_req_ready}, 64'd0);
         chk("stall.resp_valid", {63'd0, a_resp_valid}, 64'd0);
         @(negedge clk);
      end
      a_mem_rvalid = 1'b0; a_mem_gnt = 1'b1;
      @(negedge clk);
      a_mem_gnt = 1'b0; a_mem_rvalid = 1'b1; a_mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      a_mem_rvalid = 1'b0;
      chk("stall.resp_valid_end", {63'd0, a_resp_valid}, 64'd1);
      chk("stall.resp_data", {32'd0, a_resp_data}, 64'hDEAD_BEEF);

      // Reset during WAIT abandons the load
      @(negedge clk);
      a_req_valid = 1'b1; a_req_size = 3'b010; a_req_addr = 32'h0000_0020; a_req_rd = 5'd4;
      @(negedge clk);
      a_req_valid = 1'b0; a_mem_gnt = 1'b1;
      @(negedge clk);
      a_mem_gnt = 1'b0;
      chk("rstw.in_wait_busy", {63'd0, a_busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rstw.req_ready", {63'd0, a_req_ready}, 64'd1);
      chk("rstw.busy", {63'd0, a_busy}, 64'd0);
      chk("rstw.mem_addr", {32'd0, a_mem_addr}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a_mem_rvalid = 1'b1; a_mem_rdata = 32'h1234_5678;
      @(negedge clk);
      a_mem_rvalid = 1'b0;
      @(negedge clk);
      chk("rstw.no_resp", {63'd0, a_resp_valid}, 64'd0);
      chk("rstw.no_req", {63'd0, a_mem_req}, 64'd0);

      // LW at 0x6: trap when enabled, forced-aligned otherwise
`ifdef LSU_MISALIGN_TRAP_EN
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 3'b010; a_req_addr = 32'h0000_0006; a_req_rd = 5'd9;
      @(negedge clk);
      a_req_valid = 1'b0;
      chk("trap.err", {63'd0, a_err}, 64'd1);
      chk("trap.mem_req", {63'd0, a_mem_req}, 64'd0);
      chk("trap.ready_low", {63'd0, a_req_ready}, 64'd0);
      @(negedge clk);
      chk("trap.err_drop", {63'd0, a_err}, 64'd0);
      chk("trap.ready", {63'd0, a_req_ready}, 64'd1);
      chk("trap.mem_req2", {63'd0, a_mem_req}, 64'd0);
      @(negedge clk);
      chk("trap.no_resp", {63'd0, a_resp_valid}, 64'd0);
`else
      load32("lw_misal", 3'b010, 32'h0000_0006, 5'd9, 32'h1122_3344, 32'h0000_0004, 32'h1122_3344);
`endif

      // XLEN=64: LWU upper word, then SW replicated into upper lanes
      @(negedge clk);
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_size = 3'b110; b_req_addr = 64'h4; b_req_rd = 5'd12;
      @(negedge clk);
      b_req_valid = 1'b0;
      chk("lwu64.mem_addr", b_mem_addr, 64'h0);
      chk("lwu64.mem_req", {63'd0, b_mem_req}, 64'd1);
      b_mem_gnt = 1'b1;
      @(negedge clk);
      b_mem_gnt = 1'b0; b_mem_rvalid = 1'b1; b_mem_rdata = 64'h8000_0001_0000_0000;
      @(negedge clk);
      b_mem_rvalid = 1'b0;
      chk("lwu64.resp_valid", {63'd0, b_resp_valid}, 64'd1);
      chk("lwu64.resp_data", b_resp_data, 64'h0000_0000_8000_0001);
      chk("lwu64.resp_rd", {59'd0, b_resp_rd}, 64'd12);
      @(negedge clk);
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 3'b010; b_req_addr = 64'hC;
      b_req_wdata = 64'hFFFF_FFFF_1234_5678;
      @(negedge clk);
      b_req_valid = 1'b0; b_req_we = 1'b0;
      chk("sw64.mem_we", {56'd0, b_mem_we}, 64'hF0);
      chk("sw64.mem_wdata", b_mem_wdata, 64'h1234_5678_1234_5678);
      chk("sw64.mem_addr", b_mem_addr, 64'h8);
      b_mem_gnt = 1'b1;
      @(negedge clk);
      b_mem_gnt = 1'b0;
      chk("sw64.req_ready", {63'd0, b_req_ready}, 64'd1);
      chk("sw64.no_resp", {63'd0, b_resp_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
